// File: rtl/tt_um_cmpt_capture.sv
// Timestamp capture stage: extends the upstream 8-bit counter with a wrap epoch.
// It also queues one {epoch, cmpt} stamp per synchronised event rising edge into a small FIFO.
module tt_um_cmpt_capture #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               cmpt,
    input  logic                     evt_in,
    input  logic                     ts_ready,
    input  logic                     clr_ovf,
    output logic [11:0]              ts_data,
    output logic                     ts_valid,
    output logic [$clog2(DEPTH):0]   ts_count,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]             prev_cmpt;
    logic [3:0]             epoch;
    logic [SYNC_STAGES-1:0] sync;
    logic                   evt_d;
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [11:0]            mem [DEPTH];

    logic        wrap;
    logic        evt_s;
    logic        push;
    logic        pop;
    logic        full;
    logic        do_write;
    logic        drop;
    logic [11:0] stamp;
    logic [AW:0] count_next;

    assign wrap     = (prev_cmpt == 8'hFF) && (cmpt == 8'h00);
    assign evt_s    = sync[SYNC_STAGES-1];
    assign push     = evt_s & ~evt_d;
    assign pop      = ts_valid & ts_ready;
    assign full     = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign do_write = push & (~full | pop);
    assign drop     = push & full & ~pop;
    // Same-cycle wrap is folded in so stamps stay monotonic across the rollover.
    assign stamp    = {epoch + {3'b000, wrap}, cmpt};
    assign ts_data  = ts_valid ? mem[rd_ptr[AW-1:0]] : 12'h000;

    always_comb begin
        count_next = ts_count;
        case ({do_write, pop})
            2'b10:   count_next = ts_count + 1'b1;
            2'b01:   count_next = ts_count - 1'b1;
            default: count_next = ts_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_cmpt <= 8'h00;
            epoch     <= 4'h0;
            sync      <= '0;
            evt_d     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ts_count  <= '0;
            ts_valid  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            prev_cmpt <= cmpt;
            if (wrap) begin
                epoch <= epoch + 4'h1;
            end
            sync  <= {sync[SYNC_STAGES-2:0], evt_in};
            evt_d <= evt_s;
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ts_count <= count_next;
            ts_valid <= (count_next != '0);
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= stamp;
        end
    end

endmodule

// File: tb/tb_tt_um_cmpt_capture.sv
// Directed bench for tt_um_cmpt_capture: the bench plays the upstream counter on cmpt.
// Every check compares against hand-computed stamps.
module tb_tt_um_cmpt_capture;

    logic        clk;
    logic        rst;
    logic [7:0]  cmpt;
    logic        evt_in;
    logic        ts_ready;
    logic        clr_ovf;
    logic [11:0] ts_data;
    logic        ts_valid;
    logic [2:0]  ts_count;
    logic        ovf;

    logic [7:0]  cnt;
    int          tests_run;
    int          tests_failed;

    tt_um_cmpt_capture #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmpt     (cmpt),
        .evt_in   (evt_in),
        .ts_ready (ts_ready),
        .clr_ovf  (clr_ovf),
        .ts_data  (ts_data),
        .ts_valid (ts_valid),
        .ts_count (ts_count),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: cmpt carries the running count, outputs are sampled 1 ns after the edge.
    task automatic applyStimulus(input logic e, input logic r, input logic clr);
        cmpt     = cnt;
        evt_in   = e;
        ts_ready = r;
        clr_ovf  = clr;
        @(posedge clk);
        #1;
        cnt = cnt + 8'h01;
    endtask

    // A one-cycle event pulse followed by low cycles; the stamp lands on the third clock.
    task automatic pulseEvent(input int low_cycles);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < low_cycles; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic exp_valid, input logic [11:0] exp_data,
                               input logic [2:0] exp_count, input logic exp_ovf);
        tests_run++;
        assert (ts_valid === exp_valid) else begin
            tests_failed++;
            $error("[TB] FAIL %s ts_valid: got %b expected %b", tag, ts_valid, exp_valid);
        end
        tests_run++;
        assert (ts_data === exp_data) else begin
            tests_failed++;
            $error("[TB] FAIL %s ts_data: got %h expected %h", tag, ts_data, exp_data);
        end
        tests_run++;
        assert (ts_count === exp_count) else begin
            tests_failed++;
            $error("[TB] FAIL %s ts_count: got %0d expected %0d", tag, ts_count, exp_count);
        end
        tests_run++;
        assert (ovf === exp_ovf) else begin
            tests_failed++;
            $error("[TB] FAIL %s ovf: got %b expected %b", tag, ovf, exp_ovf);
        end
    endtask

    logic [11:0] drain_exp [4];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cnt      = 8'h00;
        rst      = 1'b1;
        cmpt     = 8'h00;
        evt_in   = 1'b0;
        ts_ready = 1'b0;
        clr_ovf  = 1'b0;
        #1;
        checkOutput("reset", 1'b0, 12'h000, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        $display("[TB] single capture");
        cnt = 8'h0E;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("no_bypass", 1'b0, 12'h000, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("single", 1'b1, 12'h010, 3'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("single_pop", 1'b0, 12'h000, 3'd0, 1'b0);

        $display("[TB] wrap epoch");
        for (int i = 0; i < 492; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wrap_cycle", 1'b1, 12'h200, 3'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        pulseEvent(2);
        checkOutput("two_wraps", 1'b1, 12'h205, 3'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("two_wraps_pop", 1'b0, 12'h000, 3'd0, 1'b0);

        $display("[TB] overflow");
        for (int i = 0; i < 5; i++) pulseEvent(3);
        drain_exp[0] = 12'h209;
        drain_exp[1] = 12'h20D;
        drain_exp[2] = 12'h211;
        drain_exp[3] = 12'h215;
        checkOutput("ovf_full", 1'b1, 12'h209, 3'd4, 1'b1);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("ovf_drain%0d", i), 1'b1, drain_exp[i], 3'(4 - i), 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("ovf_empty", 1'b0, 12'h000, 3'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("ovf_clear", 1'b0, 12'h000, 3'd0, 1'b0);

        $display("[TB] full with push and pop");
        for (int i = 0; i < 4; i++) pulseEvent(3);
        checkOutput("pp_full", 1'b1, 12'h222, 3'd4, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pp_same_cycle", 1'b1, 12'h226, 3'd4, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        drain_exp[0] = 12'h226;
        drain_exp[1] = 12'h22A;
        drain_exp[2] = 12'h22E;
        drain_exp[3] = 12'h232;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("pp_drain%0d", i), 1'b1, drain_exp[i], 3'(4 - i), 1'b0);
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        checkOutput("pp_empty", 1'b0, 12'h000, 3'd0, 1'b0);

        $display("[TB] held level and pulse train");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("held", 1'b1, 12'h23A, 3'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 256 * 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) pulseEvent(7);
        checkOutput("train", 1'b1, 12'h752, 3'd4, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("train_pop", 1'b1, 12'h75A, 3'd3, 1'b1);

        $display("[TB] reset mid-operation");
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst", 1'b0, 12'h000, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 8'h01;
        pulseEvent(2);
        checkOutput("post_rst", 1'b1, 12'h003, 3'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tt_um_cmpt_capture.md
# tt_um_cmpt_capture

Timestamp capture stage downstream of the 8-bit wrapping counter `tt_um_Compt_8bits`. It takes the counter value `cmpt` and extends it with a 4-bit wrap epoch to form a 12-bit timestamp. It synchronises an asynchronous event pin and, on each event rising edge, pushes the current timestamp into a small FIFO. Captured timestamps are drained through a valid/ready interface.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of two, 2..16.
- `SYNC_STAGES`, default 2: synchroniser flops on `evt_in`; minimum 2.
- `clk` input, 1 bit: clock, shared with the upstream counter.
- `rst` input, 1 bit: reset, asynchronous, active-high. Drives the same net as the counter's reset.
- `cmpt` input, 8 bits: counter value from `tt_um_Compt_8bits`, synchronous to `clk`.
- `evt_in` input, 1 bit: asynchronous event pin; a rising edge captures a timestamp.
- `ts_ready` input, 1 bit: consumer accepts the head entry.
- `clr_ovf` input, 1 bit: synchronous clear of `ovf`.
- `ts_data` output, 12 bits: head timestamp `{epoch[3:0], cmpt[7:0]}`. Reads 0 when the FIFO is empty.
- `ts_valid` output, 1 bit: FIFO is not empty.
- `ts_count` output, log2(DEPTH)+1 bits: number of occupied entries.
- `ovf` output, 1 bit: sticky flag; set when a capture was dropped.

## Operation
- **Reset values:** all of the following are 0:
  - outputs `ts_data`, `ts_valid`, `ts_count`, `ovf`;
  - internal state: epoch, `prev_cmpt`, synchroniser chain, edge-detect flop, read pointer, write pointer.
- **Wrap detect:** `wrap = (prev_cmpt == 8'hFF) && (cmpt == 8'h00)`.
  - `prev_cmpt` registers `cmpt` every cycle.
  - A 0 after a reset does not count as a wrap, because `prev_cmpt` resets to 0.
- **Epoch:** a 4-bit register that increments by 1 on each cycle where `wrap` is true. It rolls over from 15 to 0 with no flag.
- **Event path:**
  - `evt_in` passes through `SYNC_STAGES` flops to give `evt_s`.
  - One further flop holds `evt_d`.
  - `push = evt_s & ~evt_d`, so there is one push per rising edge, whatever the pulse width.
  - A level held high produces no further pushes.
- **Captured value:** `{epoch + wrap, cmpt}`, taken from the cycle where `push` is true. The epoch therefore already reflects a wrap happening in the same cycle, so the timestamp is monotonic across the wrap.
- **FIFO:**
  - Circular buffer with pointers one bit wider than the address, giving the full/empty distinction.
  - `pop = ts_valid & ts_ready`.
- **Push/pop rules:**
  - Empty, push only: entry written; `ts_valid` rises the next cycle. There is no bypass.
  - Full, push only: the capture is dropped, the FIFO is unchanged and `ovf` is set.
  - Full, push and pop together: the pop retires the head and the push is accepted. The count stays at DEPTH and `ovf` is not set.
  - Empty, pop: impossible, since `ts_valid` is 0; `ts_ready` is ignored.
  - Otherwise, push and pop together: both take effect and the count is unchanged.
- **ovf:**
  - Sticky until `clr_ovf`.
  - If `clr_ovf` and a drop occur in the same cycle, set wins.
  - `clr_ovf` has no effect on FIFO contents.
- **Reset mid-operation:** all entries are discarded immediately (asynchronous), and the epoch and `ovf` clear. A capture in flight in the synchroniser is lost.

## Timing
- **Capture latency:** with `SYNC_STAGES=2`, `evt_in` must meet setup before edge E0. Then:
  - `evt_s` is high after E1;
  - `push` is true in the cycle E1–E2 and the entry is written at E2;
  - `ts_valid` and `ts_data` are valid after E2;
  - the captured `cmpt` is the value present in cycle E1–E2.
- **Latency in general:** SYNC_STAGES+1 edges from the `evt_in` sample to `ts_valid`.
- **Pop timing:**
  - A pop at edge P updates `ts_data` and `ts_count` after P.
  - Back-to-back pops at one per cycle are supported.
- **Minimum event spacing:** one capture per 2 clocks. `evt_in` must be low for at least SYNC_STAGES+1 cycles between edges to guarantee detection.
- **Output paths:** `ts_valid`, `ts_count` and `ovf` come straight from registers. `ts_data` is a registered-array read mux with no combinational path from inputs.

## Test plan
- **Single capture:** release reset, counter running; rising edge on `evt_in` with `cmpt`=0x10 in the push cycle, `ts_ready`=0.
  - `ts_valid`=1 after 3 edges, `ts_data`=0x010, `ts_count`=1.
  - Then `ts_ready`=1 for one cycle → `ts_valid`=0, `ts_data`=0.
- **Wrap epoch:** let the counter wrap twice, then capture at `cmpt`=0x05 → `ts_data`=0x205.
  - Capture in the exact cycle `cmpt` goes 0xFF→0x00 after one prior wrap → `ts_data`=0x200.
- **Overflow:** `DEPTH`=4, `ts_ready`=0, 5 spaced events.
  - `ts_count`=4, `ovf`=1, and the first four timestamps drain in order.
  - `clr_ovf` → `ovf`=0.
- **Full with simultaneous push/pop:** FIFO full, `ts_ready`=1 in the push cycle.
  - `ts_count` stays 4 and `ovf` stays 0.
  - The new entry appears last when drained.
- **Held level:** hold `evt_in` high for 20 cycles → exactly one entry. An 8-cycle spacing train of pulses → one entry per pulse.
- **Reset mid-operation:** 3 entries, epoch=7, `ovf`=1; assert `rst` asynchronously mid-cycle.
  - All outputs are 0 immediately.
  - After release, the next capture at `cmpt`=0x03 → `ts_data`=0x003.
